// File: rtl/goldschmidt_ctrl.sv
// Sequencer for the 16-bit Goldschmidt divider datapath: operand capture,
// seed/refinement control and quotient capture behind a start/done handshake.
module goldschmidt_ctrl #(
  parameter int WIDTH = 16,
  parameter int ITERS = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] N_in,
  input  logic [WIDTH-1:0] D_in,
  input  logic [WIDTH-1:0] IA_in,
  input  logic [WIDTH-1:0] result,
  output logic [WIDTH-1:0] N,
  output logic [WIDTH-1:0] D,
  output logic [WIDTH-1:0] IA,
  output logic             load_regN,
  output logic             load_regD,
  output logic [1:0]       sel_ND_mux,
  output logic             sel_K_mux,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient
);

  generate
    if (ITERS < 1 || ITERS > 15) begin : g_bad_iters
      $error("goldschmidt_ctrl: ITERS must be in 1..15");
    end
  endgenerate

  localparam logic [3:0] LAST = 4'(ITERS - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEED_D,
    SEED_N,
    ITER_D,
    ITER_N,
    CAPTURE,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] n_q, n_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [WIDTH-1:0] ia_q, ia_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  // ctl = {load_regN, load_regD, sel_ND_mux, sel_K_mux}
  logic [4:0]       ctl_q, ctl_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    n_d     = n_q;
    d_d     = d_q;
    ia_d    = ia_q;
    quo_d   = quo_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = SEED_D;
          n_d     = N_in;
          d_d     = D_in;
          ia_d    = IA_in;
          cnt_d   = '0;
        end
      end
      SEED_D:  state_d = SEED_N;
      SEED_N:  state_d = ITER_D;
      ITER_D:  state_d = ITER_N;
      ITER_N: begin
        if (cnt_q == LAST) begin
          state_d = CAPTURE;
        end else begin
          cnt_d   = cnt_q + 4'd1;
          state_d = ITER_D;
        end
      end
      CAPTURE: begin
        quo_d   = result;
        state_d = DONE;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs are decoded from the next state so the flops equal a
  // Moore decode of the state register, with no output glitches.
  always_comb begin
    ctl_d  = 5'b00001;
    busy_d = 1'b1;
    done_d = 1'b0;
    case (state_d)
      IDLE:    busy_d = 1'b0;
      SEED_D:  ctl_d  = 5'b01001;
      SEED_N:  ctl_d  = 5'b10011;
      ITER_D:  ctl_d  = 5'b01100;
      ITER_N:  ctl_d  = 5'b10110;
      CAPTURE: ctl_d  = 5'b00110;
      DONE:    done_d = 1'b1;
      default: busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      n_q     <= '0;
      d_q     <= '0;
      ia_q    <= '0;
      quo_q   <= '0;
      ctl_q   <= 5'b00001;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      n_q     <= n_d;
      d_q     <= d_d;
      ia_q    <= ia_d;
      quo_q   <= quo_d;
      ctl_q   <= ctl_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign N          = n_q;
  assign D          = d_q;
  assign IA         = ia_q;
  assign load_regN  = ctl_q[4];
  assign load_regD  = ctl_q[3];
  assign sel_ND_mux = ctl_q[2:1];
  assign sel_K_mux  = ctl_q[0];
  assign busy       = busy_q;
  assign done       = done_q;
  assign quotient   = quo_q;

endmodule

// File: tb/tb_goldschmidt_ctrl.sv
// Bench for goldschmidt_ctrl: ITERS=4 and ITERS=1 instances against a
// position-in-operation model, plus directed literal checks.
module tb_goldschmidt_ctrl;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  logic [15:0] n_in = '0, d_in = '0, ia_in = '0;
  logic [15:0] result;
  logic        fixed_res = 1'b0;
  logic [31:0] cyc = '0;
  logic        chk_en = 1'b0;

  int total = 0;
  int passed = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // stand-in datapath result: changes every cycle unless pinned
  assign result = fixed_res ? 16'h1331 : {cyc[7:0], ~cyc[7:0]};

  logic [15:0] n4, d4, ia4, q4, n1, d1, ia1, q1;
  logic        ln4, ld4, k4, busy4, done4;
  logic        ln1, ld1, k1, busy1, done1;
  logic [1:0]  sel4, sel1;

  goldschmidt_ctrl #(.WIDTH(16), .ITERS(4)) dut4 (
    .clk(clk), .reset(reset), .start(start),
    .N_in(n_in), .D_in(d_in), .IA_in(ia_in), .result(result),
    .N(n4), .D(d4), .IA(ia4),
    .load_regN(ln4), .load_regD(ld4),
    .sel_ND_mux(sel4), .sel_K_mux(k4),
    .busy(busy4), .done(done4), .quotient(q4)
  );

  goldschmidt_ctrl #(.WIDTH(16), .ITERS(1)) dut1 (
    .clk(clk), .reset(reset), .start(start),
    .N_in(n_in), .D_in(d_in), .IA_in(ia_in), .result(result),
    .N(n1), .D(d1), .IA(ia1),
    .load_regN(ln1), .load_regD(ld1),
    .sel_ND_mux(sel1), .sel_K_mux(k1),
    .busy(busy1), .done(done1), .quotient(q1)
  );

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // Model: t = cycle index within an operation (0 = idle, 1 = first
  // busy cycle, done at 4+2*iters), quotient taken at cycle 3+2*iters.
  int          its [2] = '{4, 1};
  int          t [2];
  logic [15:0] mq [2], mn [2], md [2], mia [2];

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (!reset) begin
        t[i] = 0; mq[i] = '0; mn[i] = '0; md[i] = '0; mia[i] = '0;
      end else if (t[i] == 0) begin
        if (start) begin
          t[i] = 1; mn[i] = n_in; md[i] = d_in; mia[i] = ia_in;
        end
      end else if (t[i] == 4 + 2 * its[i]) begin
        t[i] = 0;
      end else begin
        if (t[i] == 3 + 2 * its[i]) mq[i] = result;
        t[i] = t[i] + 1;
      end
    end
  end

  // {load_regN, load_regD, sel_ND_mux, sel_K_mux, busy, done}
  function automatic logic [6:0] exp_ctrl(input int tt, input int it);
    if (tt == 0) return 7'b0000100;
    if (tt == 1) return 7'b0100110;
    if (tt == 2) return 7'b1001110;
    if (tt <= 2 + 2 * it)
      return ((tt - 3) % 2 == 0) ? 7'b0110010 : 7'b1011010;
    if (tt == 3 + 2 * it) return 7'b0011010;
    return 7'b0000111;
  endfunction

  always @(negedge clk) begin
    if (chk_en) begin
      chk("ctrl4", {ln4, ld4, sel4, k4, busy4, done4}, exp_ctrl(t[0], 4));
      chk("quot4", q4, mq[0]);
      chk("ndia4", {n4, d4, ia4}, {mn[0], md[0], mia[0]});
      chk("ctrl1", {ln1, ld1, sel1, k1, busy1, done1}, exp_ctrl(t[1], 1));
      chk("quot1", q1, mq[1]);
      chk("ndia1", {n1, d1, ia1}, {mn[1], md[1], mia[1]});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle();
    int k = 0;
    step();
    while ((busy4 || busy1) && k < 60) begin
      step();
      k++;
    end
    chk("drain_timeout", 64'(k < 60), 64'd1);
  endtask

  logic [23:0] esel_v = {2'b00, 2'b11, 2'b11, 2'b10, 2'b11, 2'b10,
                         2'b11, 2'b10, 2'b11, 2'b10, 2'b01, 2'b00};
  logic [11:0] ek_v = 12'b100000000011;

  task automatic run_nom(input logic [15:0] ia, input logic [15:0] nn,
                         input logic [15:0] dd);
    int dn4 = 0, dn1 = 0, lds = 0, ldn = 0;
    ia_in = ia; n_in = nn; d_in = dd;
    start = 1'b1;
    step();
    start = 1'b0;
    for (int n = 1; n <= 40 && dn4 == 0; n++) begin
      @(negedge clk);
      if (n <= 12) begin
        chk($sformatf("sel_c%0d", n), {sel4, k4},
            {esel_v[2*(n-1) +: 2], ek_v[n-1]});
        lds += int'(ld4);
        ldn += int'(ln4);
      end
      if (done1 && dn1 == 0) dn1 = n;
      if (done4) dn4 = n;
    end
    chk("done_cycle4", dn4, 12);
    chk("done_cycle1", dn1, 6);
    chk("loads_D", lds, 5);
    chk("loads_N", ldn, 5);
  endtask

  int dts [3];
  int nd;
  int dc;
  logic b13, b14;

  initial begin
    // reset held with start high
    reset = 1'b0; start = 1'b1;
    n_in = 16'hC000; d_in = 16'hA000; ia_in = 16'hA000;
    step();
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_busy", busy4, 1'b0);
    chk("rst_done", done4, 1'b0);
    chk("rst_quot", q4, 16'h0000);
    chk("rst_ctrl", {ln4, ld4, sel4, k4}, 5'b00001);
    step();
    reset = 1'b1;
    step();
    start = 1'b0;
    @(negedge clk);
    chk("accept_after_rst", busy4, 1'b1);
    wait_idle();

    // nominal trace with a pinned datapath result
    fixed_res = 1'b1;
    run_nom(16'hA000, 16'hC000, 16'hA000);
    chk("quot_dp4", q4, 16'h1331);
    chk("quot_dp1", q1, 16'h1331);
    wait_idle();
    fixed_res = 1'b0;
    repeat (3) step();
    chk("quot_held", q4, 16'h1331);

    // busy protection
    n_in = 16'h1111; d_in = 16'h2222; ia_in = 16'h3333;
    start = 1'b1;
    step();
    dc = 0;
    for (int n = 1; n <= 25; n++) begin
      start = (n <= 10);
      n_in = 16'($urandom); d_in = 16'($urandom); ia_in = 16'($urandom);
      @(negedge clk);
      if (done4) dc++;
      if (n == 11) chk("busy_hold_ndia", {n4, d4, ia4},
                       {16'h1111, 16'h2222, 16'h3333});
      step();
    end
    chk("busy_one_done", dc, 1);
    start = 1'b0;
    wait_idle();

    // back-to-back with start held
    start = 1'b1;
    step();
    nd = 0;
    b13 = 1'b1; b14 = 1'b0;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (done4 && nd < 3) begin
        dts[nd] = n;
        nd++;
      end
      if (n == 13) b13 = busy4;
      if (n == 14) b14 = busy4;
    end
    start = 1'b0;
    chk("b2b_count", nd, 3);
    chk("b2b_first", dts[0], 12);
    chk("b2b_gap1", dts[1] - dts[0], 13);
    chk("b2b_gap2", dts[2] - dts[1], 13);
    chk("b2b_idle13", b13, 1'b0);
    chk("b2b_busy14", b14, 1'b1);
    wait_idle();

    // abort in ITER_N of the second iteration
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (5) step();
    @(negedge clk);
    chk("abort_pre_state", {ln4, sel4, k4}, 4'b1110);
    #1 reset = 1'b0;
    step();
    reset = 1'b1;
    @(negedge clk);
    chk("abort_busy", busy4, 1'b0);
    chk("abort_quot", q4, 16'h0000);
    dc = 0;
    for (int n = 0; n < 10; n++) begin
      @(negedge clk);
      if (done4) dc++;
    end
    chk("abort_no_done", dc, 0);
    step();
    run_nom(16'hA000, 16'hC000, 16'hA000);
    wait_idle();

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
